// File: rtl/glove_pkg.sv
// Shared types and sizing for the glove sensor front end.
package glove_pkg;
  localparam int N_CH   = 8;
  localparam int N_STEP = 5;
  localparam int W      = 16;
  localparam int N_WIN  = N_CH * N_STEP;
  localparam int CW     = $clog2(N_CH);
  localparam int SW     = $clog2(N_STEP + 1);

  typedef logic signed [W-1:0] sample_t;
  typedef sample_t window_t [0:N_WIN-1];
  typedef enum logic {S_FILL, S_STREAM} state_t;

  // One incoming sample beat; vld already excludes the clear cycle.
  typedef struct packed {
    logic    vld;
    logic    sof;
    sample_t smp;
  } beat_t;

  // Clamp a W+1 bit difference into W bits: overflow shows as top two bits differing.
  function automatic sample_t sat_w(input logic signed [W:0] d);
    if (d[W] ^ d[W-1]) sat_w = {d[W], {(W-1){~d[W]}}};
    else               sat_w = d[W-1:0];
  endfunction
endpackage

// File: rtl/calib_sat.sv
// Offset subtraction with saturation to the sample width.
module calib_sat
  import glove_pkg::*;
(
  input  sample_t i_sample,
  input  sample_t i_offset,
  output sample_t o_corr
);
  logic signed [W:0] diff;

  // Sign-extend both operands so the difference cannot wrap.
  always_comb diff = {i_sample[W-1], i_sample} - {i_offset[W-1], i_offset};

  assign o_corr = sat_w(diff);
endmodule

// File: rtl/sensor_window_buffer.sv
// Sliding window of calibrated glove samples feeding the gesture core.
module sensor_window_buffer
  import glove_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [W-1:0]       i_sample,
  input  logic               i_cal_we,
  input  logic [CW-1:0]      i_cal_ch,
  input  logic [W-1:0]       i_cal_val,
  input  logic               i_ready,
  output logic               o_next,
  output logic [N_WIN*W-1:0] o_data,
  output logic               o_overrun,
  output logic               o_sync_err
);
  sample_t       offs [N_CH];
  sample_t       row  [0:N_CH-2];
  window_t       win;
  sample_t       corr;
  beat_t         bt;
  logic [CW-1:0] ch, wr_ch;
  logic [SW-1:0] step;
  logic          pend, commit, fresh, sync_hit;
  state_t        state, state_nx;

  assign bt       = '{vld: i_valid & ~i_clear, sof: i_sof, smp: i_sample};
  assign wr_ch    = bt.sof ? '0 : ch;
  assign commit   = bt.vld && (wr_ch == CW'(N_CH - 1));
  assign fresh    = commit && ((state == S_STREAM) || (step == SW'(N_STEP - 1)));
  assign sync_hit = bt.vld && bt.sof && (ch != '0);

  calib_sat u_cal (
    .i_sample (bt.smp),
    .i_offset (offs[wr_ch]),
    .o_corr   (corr)
  );

  // Calibration offsets; a write lands at the edge so same-cycle samples see the old value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) offs[i] <= '0;
    end else if (i_cal_we) begin
      offs[i_cal_ch] <= i_cal_val;
    end
  end

  // Staging row for channels 0..N_CH-2; the last channel goes straight into the window.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH - 1; i++) row[i] <= '0;
    end else if (bt.vld && !commit) begin
      row[wr_ch] <= corr;
    end
  end

  // Window shifts one step per commit; clear leaves it untouched.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_WIN; i++) win[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < N_WIN - N_CH; i++) win[i] <= win[i + N_CH];
      for (int c = 0; c < N_CH - 1; c++) win[N_WIN - N_CH + c] <= row[c];
      win[N_WIN - 1] <= corr;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_FILL;
    else          state <= state_nx;
  end

  // Fill ends on the commit that completes the first full window.
  always_comb begin
    state_nx = state;
    if (i_clear)    state_nx = S_FILL;
    else if (fresh) state_nx = S_STREAM;
  end

  // Counters, delivery handshake and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      ch         <= '0;
      step       <= '0;
      pend       <= 1'b0;
      o_next     <= 1'b0;
      o_overrun  <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      if (bt.vld) ch <= commit ? '0 : wr_ch + 1'b1;
      if (commit && step != SW'(N_STEP)) step <= step + 1'b1;
      if (sync_hit) o_sync_err <= 1'b1;
      if (fresh && pend) o_overrun <= 1'b1;
      if ((fresh || pend) && i_ready && !o_next) begin
        o_next <= 1'b1;
        pend   <= 1'b0;
      end else begin
        o_next <= 1'b0;
        if (fresh) pend <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_WIN; i++) begin : g_out
    assign o_data[i*W +: W] = win[i];
  end
endmodule

// File: tb/tb_sensor_window_buffer.sv
// Scoreboard bench: stimulus queues expected windows, the monitor checks each o_next.
module tb_sensor_window_buffer;
  import glove_pkg::*;
  localparam int DW = N_WIN * W;

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_clear, i_valid, i_sof, i_cal_we, i_ready;
  logic [W-1:0]  i_sample, i_cal_val;
  logic [CW-1:0] i_cal_ch;
  logic          o_next, o_overrun, o_sync_err;
  logic [DW-1:0] o_data;

  int            total = 0, bad = 0, nxt_cnt = 0;
  logic [DW-1:0] sbq [$];
  logic [DW-1:0] exp_win, mexp;
  sample_t       er [N_CH];
  int            mi;

  always #5 i_clk = ~i_clk;

  sensor_window_buffer dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_clear),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .i_sample   (i_sample),
    .i_cal_we   (i_cal_we),
    .i_cal_ch   (i_cal_ch),
    .i_cal_val  (i_cal_val),
    .i_ready    (i_ready),
    .o_next     (o_next),
    .o_data     (o_data),
    .o_overrun  (o_overrun),
    .o_sync_err (o_sync_err)
  );

  // Monitor: every o_next must match the oldest queued window.
  always @(negedge i_clk) begin
    if (o_next === 1'b1) begin
      nxt_cnt++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL deliver: unexpected o_next got 1 want 0");
      end else begin
        mexp = sbq.pop_front();
        if (o_data !== mexp) begin
          bad++;
          mi = 0;
          while (mi < N_WIN - 1 && o_data[mi*W +: W] === mexp[mi*W +: W]) mi++;
          $display("FAIL deliver: o_data[%0d] got %0d want %0d", mi,
                   $signed(o_data[mi*W +: W]), $signed(mexp[mi*W +: W]));
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic int el(input int i);
    return int'($signed(o_data[i*W +: W]));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic sof, input int s);
    i_valid  = v;
    i_sof    = sof;
    i_sample = s[W-1:0];
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_sof    = 1'b0;
    i_cal_we = 1'b0;
    i_clear  = 1'b0;
  endtask

  // Row base+c, except channel xch which sends xs and expects xe.
  task automatic send_row_x(input int base, input int xch, input int xs, input int xe);
    logic [N_CH*W-1:0] rf;
    int s, e;
    for (int c = 0; c < N_CH; c++) begin
      s = (c == xch) ? xs : base + c;
      e = (c == xch) ? xe : base + c;
      er[c] = e[W-1:0];
      beat(1'b1, c == 0, s);
    end
    for (int c = 0; c < N_CH; c++) rf[c*W +: W] = er[c];
    exp_win = {rf, exp_win[DW-1:N_CH*W]};
  endtask

  task automatic send_row(input int base);
    send_row_x(base, -1, 0, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_sample = '0; i_cal_we = 1'b0; i_cal_ch = '0; i_cal_val = '0; i_ready = 1'b1;
    exp_win = '0;
    idle(3);
    i_rst_n = 1'b1;
    chk("rst_next", int'(o_next), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    chk("rst_sync", int'(o_sync_err), 0);
    chk("rst_data_zero", int'(o_data === '0), 1);

    // 1: fill five rows, single delivery right after the 40th sample
    for (int r = 0; r < 4; r++) send_row(100 * r);
    idle(2);
    chk("fill_no_next", nxt_cnt, 0);
    send_row(400);
    sbq.push_back(exp_win);
    chk("fill_latency", int'(o_next), 1);
    idle(1);
    chk("fill_pulse_len", int'(o_next), 0);
    chk("fill_d13", el(13), 105);
    chk("fill_d39", el(39), 407);
    chk("fill_cnt", nxt_cnt, 1);

    // 2: saturation both directions on channel 3
    i_cal_we = 1'b1; i_cal_ch = 3'd3; i_cal_val = 16'h8000;
    beat(1'b0, 1'b0, 0);
    send_row_x(500, 3, 32767, 32767);
    sbq.push_back(exp_win);
    idle(2);
    chk("sat_pos", el(35), 32767);
    i_cal_we = 1'b1; i_cal_ch = 3'd3; i_cal_val = 16'h0001;
    beat(1'b0, 1'b0, 0);
    send_row_x(600, 3, -32768, -32768);
    sbq.push_back(exp_win);
    idle(2);
    chk("sat_neg", el(35), -32768);
    chk("sat_prev_step", el(27), 32767);
    i_cal_we = 1'b1; i_cal_ch = 3'd3; i_cal_val = 16'h0000;
    beat(1'b0, 1'b0, 0);

    // 3: core busy across two windows -> overrun, newest delivered later
    i_ready = 1'b0;
    send_row(700);
    send_row(800);
    idle(3);
    chk("busy_no_next", nxt_cnt, 3);
    chk("overrun_set", int'(o_overrun), 1);
    sbq.push_back(exp_win);
    i_ready = 1'b1;
    idle(3);
    chk("busy_deliver", nxt_cnt, 4);
    chk("busy_step4", el(39), 807);
    chk("busy_step3", el(31), 707);
    chk("overrun_sticky", int'(o_overrun), 1);

    // 4: resync mid-row drops the partial without shifting
    beat(1'b1, 1'b1, 900);
    beat(1'b1, 1'b0, 901);
    beat(1'b1, 1'b0, 902);
    chk("sync_clean", int'(o_sync_err), 0);
    send_row(1000);
    sbq.push_back(exp_win);
    idle(2);
    chk("sync_err", int'(o_sync_err), 1);
    chk("sync_cnt", nxt_cnt, 5);

    // 5: clear mid-row in stream mode refills from scratch
    beat(1'b1, 1'b1, 1100);
    beat(1'b1, 1'b0, 1101);
    beat(1'b1, 1'b0, 1102);
    i_clear = 1'b1;
    beat(1'b1, 1'b0, 1103);
    chk("clr_overrun", int'(o_overrun), 0);
    chk("clr_sync", int'(o_sync_err), 0);
    chk("clr_next", int'(o_next), 0);
    chk("clr_data_kept", int'(o_data === exp_win), 1);
    for (int r = 0; r < 4; r++) send_row(1200 + 100 * r);
    idle(2);
    chk("clr_refill_wait", nxt_cnt, 5);
    send_row(1600);
    sbq.push_back(exp_win);
    idle(2);
    chk("clr_refill_cnt", nxt_cnt, 6);

    // 6: offset write coincident with a ch0 sample applies from the next sample on
    i_cal_we = 1'b1; i_cal_ch = 3'd0; i_cal_val = 16'd50;
    send_row(2000);
    sbq.push_back(exp_win);
    idle(2);
    send_row_x(2100, 0, 2100, 2050);
    sbq.push_back(exp_win);
    idle(2);
    chk("cal_new", el(32), 2050);
    chk("cal_old", el(24), 2000);
    chk("cal_cnt", nxt_cnt, 8);

    idle(2);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
